fetch_buffer: RTL and testbench

- Consumer end of the program-counter fetch path. Receives each issued PC and the synchronous instruction-memory read data that follows it one cycle later.
- Queues {pc, instruction} pairs in a small FIFO and presents them to decode with a valid/stall handshake.
- Drives the stall back into the PC so no fetched instruction is ever dropped.
- Discards all queued and in-flight fetches on a redirect (branch/jump), i.e. whenever the PC loads its external target.

---
 rtl/fetch_buffer.sv | 80 ++++++++
 tb/tb_fetch_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Fetch-side instruction queue: pairs each issued PC with the imem data returned a
// cycle later, buffers the pairs for decode, and back-pressures the PC when full.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         fetch_pc,
    input  logic [WIDTH-1:0]         imem_q,
    input  logic                     redirect,
    input  logic                     dec_stall,
    output logic                     pc_stall,
    output logic                     dec_valid,
    output logic [WIDTH-1:0]         dec_pc,
    output logic [WIDTH-1:0]         dec_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_req_valid;
    logic [WIDTH-1:0] r_req_pc;

    logic [WIDTH-1:0] r_mem_pc    [DEPTH];
    logic [WIDTH-1:0] r_mem_instr [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic [CW:0]      w_occupancy;

    assign w_push = r_req_valid && !redirect;
    assign w_pop  = dec_valid && !dec_stall && !redirect;

    // The in-flight fetch already owns a slot, so it counts against capacity.
    // Only registered state feeds this, keeping dec_stall off the PC stall path.
    assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_req_valid};
    assign pc_stall    = (w_occupancy >= (CW+1)'(DEPTH));

    assign dec_valid = (r_count != '0);
    assign dec_pc    = dec_valid ? r_mem_pc[r_rd_ptr]    : '0;
    assign dec_instr = dec_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign count     = r_count;

    always_ff @(posedge clock) begin
        r_req_pc <= fetch_pc;
        if (reset || redirect) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_req_valid <= 1'b0;
        end else begin
            r_req_valid <= !pc_stall;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_mem_pc[r_wr_ptr]    <= r_req_pc;
            r_mem_instr[r_wr_ptr] <= imem_q;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed vector table, hand-written flush/reset sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  fetch_pc;
    logic [WIDTH-1:0]  imem_q;
    logic              redirect;
    logic              dec_stall;
    logic              pc_stall;
    logic              dec_valid;
    logic [WIDTH-1:0]  dec_pc;
    logic [WIDTH-1:0]  dec_instr;
    logic [2:0]        count;

    always #5 clock = ~clock;

    fetch_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .fetch_pc  (fetch_pc),
        .imem_q    (imem_q),
        .redirect  (redirect),
        .dec_stall (dec_stall),
        .pc_stall  (pc_stall),
        .dec_valid (dec_valid),
        .dec_pc    (dec_pc),
        .dec_instr (dec_instr),
        .count     (count)
    );

    typedef struct {
        bit          rst;
        bit          stall;
        bit          chk;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        bit          e_ps;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    vec_t        tbl [20];
    ent_t        m_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pc_reg = 32'h0;
    logic [31:0] last_fetch = 32'h0;
    bit          model_known = 1'b0;
    bit          m_inf = 1'b0;
    logic [31:0] m_inf_pc = 32'h0;

    logic        obs_valid;
    logic        obs_ps;
    logic [31:0] obs_pc;
    logic [31:0] obs_instr;
    logic [2:0]  obs_cnt;

    function automatic vec_t mk(bit rst, bit stall, bit chk, bit v, logic [31:0] pc, int cnt, bit ps);
        vec_t r;
        r.rst = rst; r.stall = stall; r.chk = chk; r.e_valid = v;
        r.e_pc = pc; r.e_cnt = 3'(cnt); r.e_ps = ps;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, observe, then advance the model and the PC at posedge.
    // Instruction memory content at address a is a + 0x100.
    task automatic cycle(input bit rst, input bit redir, input bit stall, input logic [31:0] target);
        int sz;
        bit exp_ps;
        @(negedge clock);
        reset     = rst;
        redirect  = redir;
        dec_stall = stall;
        fetch_pc  = pc_reg;
        imem_q    = last_fetch + 32'h100;
        #1;
        obs_valid = dec_valid;
        obs_ps    = pc_stall;
        obs_pc    = dec_pc;
        obs_instr = dec_instr;
        obs_cnt   = count;
        sz     = m_q.size();
        exp_ps = (sz + int'(m_inf)) >= DEPTH;
        if (model_known) begin
            chk("model_valid", 32'(obs_valid), 32'(sz != 0));
            chk("model_pc",    obs_pc,    (sz != 0) ? m_q[0].pc    : 32'h0);
            chk("model_instr", obs_instr, (sz != 0) ? m_q[0].instr : 32'h0);
            chk("model_count", 32'(obs_cnt), 32'(sz));
            chk("model_pc_stall", 32'(obs_ps), 32'(exp_ps));
            if (obs_cnt == 3'(DEPTH)) begin
                chk("stall_when_full", 32'(obs_ps), 32'h1);
            end
        end
        @(posedge clock);
        if (rst) begin
            m_q.delete();
            m_inf = 1'b0;
            model_known = 1'b1;
        end else if (redir) begin
            m_q.delete();
            m_inf = 1'b0;
        end else begin
            if (sz != 0 && !stall) begin
                void'(m_q.pop_front());
            end
            if (m_inf) begin
                m_q.push_back('{pc: m_inf_pc, instr: m_inf_pc + 32'h100});
            end
            m_inf    = !exp_ps;
            m_inf_pc = fetch_pc;
        end
        if (rst)            pc_reg = 32'h0;
        else if (redir)     pc_reg = target;
        else if (!obs_ps)   pc_reg = pc_reg + 32'h1;
        last_fetch = fetch_pc;
    endtask

    task automatic chk_obs(input string tag, input bit v, input logic [31:0] pc, input int cnt, input bit ps);
        chk({tag, "_valid"}, 32'(obs_valid), 32'(v));
        chk({tag, "_pc"},    obs_pc,    v ? pc : 32'h0);
        chk({tag, "_instr"}, obs_instr, v ? pc + 32'h100 : 32'h0);
        chk({tag, "_count"}, 32'(obs_cnt), 32'(cnt));
        chk({tag, "_pc_stall"}, 32'(obs_ps), 32'(ps));
    endtask

    task automatic run_until_size(input int target_sz, input string tag);
        int g;
        g = 0;
        while (m_q.size() != target_sz && g < 30) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
            g++;
        end
        chk({tag, "_reach_fill"}, 32'(m_q.size()), 32'(target_sz));
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; dec_stall = 1'b0;
        fetch_pc = '0; imem_q = '0;

        // Free run, then reset, then stall-to-full and drain.
        tbl[0]  = mk(1, 0, 0, 0, 32'h0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 32'h0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 32'h0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 32'h0, 1, 0);
        tbl[4]  = mk(0, 0, 1, 1, 32'h1, 1, 0);
        tbl[5]  = mk(0, 0, 1, 1, 32'h2, 1, 0);
        tbl[6]  = mk(0, 0, 1, 1, 32'h3, 1, 0);
        tbl[7]  = mk(1, 0, 0, 0, 32'h0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 32'h0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 32'h0, 0, 0);
        tbl[10] = mk(0, 1, 1, 1, 32'h0, 1, 0);
        tbl[11] = mk(0, 1, 1, 1, 32'h0, 2, 0);
        tbl[12] = mk(0, 1, 1, 1, 32'h0, 3, 1);
        tbl[13] = mk(0, 1, 1, 1, 32'h0, 4, 1);
        tbl[14] = mk(0, 0, 1, 1, 32'h0, 4, 1);
        tbl[15] = mk(0, 0, 1, 1, 32'h1, 3, 0);
        tbl[16] = mk(0, 0, 1, 1, 32'h2, 2, 0);
        tbl[17] = mk(0, 0, 1, 1, 32'h3, 2, 0);
        tbl[18] = mk(0, 0, 1, 1, 32'h4, 2, 0);
        tbl[19] = mk(0, 0, 1, 1, 32'h5, 2, 0);

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].rst, 1'b0, tbl[i].stall, 32'h0);
            if (tbl[i].chk) begin
                chk_obs($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_pc,
                        int'(tbl[i].e_cnt), tbl[i].e_ps);
            end
        end

        // Redirect with three entries queued; the target reaches decode two cycles after issue.
        run_until_size(3, "redir3");
        cycle(1'b0, 1'b1, 1'b1, 32'h40);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_obs("redir3_flush", 1'b0, 32'h0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir3_gap_valid", 32'(obs_valid), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_obs("redir3_target", 1'b1, 32'h40, 1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect while full and stalled.
        run_until_size(4, "redir4");
        cycle(1'b0, 1'b1, 1'b1, 32'h80);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        chk_obs("redir4_flush", 1'b0, 32'h0, 0, 1'b0);

        // Mid-stream reset with two entries queued.
        run_until_size(2, "rst2");
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_obs("rst2_clear", 1'b0, 32'h0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst2_gap_valid", 32'(obs_valid), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_obs("rst2_restart", 1'b1, 32'h0, 1, 1'b0);

        // Alternating stall with continuous fetch.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 1'(i % 2), 32'h0);
        end

        // Randomized traffic with occasional redirects and resets.
        for (int i = 0; i < 600; i++) begin
            int r;
            bit rst_b, red_b, st_b;
            r     = int'($urandom_range(0, 99));
            rst_b = (r == 0);
            red_b = !rst_b && (r < 7);
            st_b  = ($urandom_range(0, 2) == 0);
            cycle(rst_b, red_b, st_b, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
